// File: rtl/gate_reduce_pipe.sv
// Two-stage pipelined reduction (OR/AND/XOR/NOR) of a WIDTH-bit vector with valid/ready flow control.
// Optional sticky accumulator of transferred results is built only when GATE_REDUCE_STICKY_EN is defined.
module gate_reduce_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             y,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             acc_clr,
   output logic             sticky
);

   localparam int NG = (WIDTH + 3) / 4;
   localparam int PW = NG * 4;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   // NOR shares the OR partial; the inversion happens only in stage 2.
   function automatic logic reduce4(input logic [3:0] g, input op_e o);
      case (o)
         OP_AND:  return &g;
         OP_XOR:  return ^g;
         default: return |g;
      endcase
   endfunction

   op_e             op_in;
   logic            en;
   logic [PW-1:0]   a_pad;
   logic [NG-1:0]   part_d, part_q;
   op_e             op1_q;
   logic            v1_q;
   logic            y_d, y_q;
   logic            v2_q;

   assign op_in     = op_e'(op);
   assign en        = !v2_q || out_ready;
   assign in_ready  = en;
   assign y         = y_q;
   assign out_valid = v2_q;

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      a_pad            = {PW{op_in == OP_AND}};
      a_pad[WIDTH-1:0] = a;
   end

   always_comb begin
      part_d = '0;
      for (int g = 0; g < NG; g++) begin
         part_d[g] = reduce4(a_pad[g*4 +: 4], op_in);
      end
   end

   always_comb begin
      y_d = 1'b0;
      case (op1_q)
         OP_AND:  y_d = &part_q;
         OP_XOR:  y_d = ^part_q;
         OP_NOR:  y_d = ~|part_q;
         default: y_d = |part_q;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values; the partial
   // registers are reset as well because y must never be X, even before the first beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         op1_q  <= OP_OR;
         part_q <= '0;
         v2_q   <= 1'b0;
         y_q    <= 1'b0;
      end else if (en) begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         if (in_valid) begin
            part_q <= part_d;
            op1_q  <= op_in;
         end
         if (v1_q) begin
            y_q <= y_d;
         end
      end
   end

`ifdef GATE_REDUCE_STICKY_EN
   logic xfer;
   logic sticky_d, sticky_q;

   assign xfer   = v2_q && out_ready;
   assign sticky = sticky_q;

   // A clear in a transfer cycle still lets that cycle's y in.
   always_comb begin
      sticky_d = sticky_q;
      if (acc_clr) begin
         sticky_d = xfer && y_q;
      end else if (xfer && y_q) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end
`else
   logic unused_acc_clr;

   assign unused_acc_clr = acc_clr;
   assign sticky         = 1'b0;
`endif

endmodule

// File: doc/gate_reduce_pipe.md
GATE_REDUCE_PIPE -- requirements
Module: gate_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 8, number of input bits reduced per beat; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a  input  WIDTH  operand vector.
REQ-005 op  input  2  reduction select: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-006 in_valid  input  1  a/op hold a beat.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 y  output  1  reduction result.
REQ-009 out_valid  output  1  y holds a result.
REQ-010 out_ready  input  1  sink accepts y this cycle.
REQ-011 acc_clr  input  1  clears the sticky accumulator.
REQ-012 sticky  output  1  OR of all y values transferred since the last clear.

Function
REQ-013 Accept: beat accepted when in_valid && in_ready; transfer: result leaves when out_valid && out_ready.
REQ-014 Two-stage pipeline: stage 1 registers per-group partial results for groups of 4 bits (ceil(WIDTH/4) groups) plus the latched op; stage 2 registers the final y.
REQ-015 Padding bits of a partial last group take the op identity: 1 for AND, 0 for OR/XOR/NOR.
REQ-016 Stage 1 uses OR partials for op 00/11, AND for 01, XOR for 10; stage 2 combines the partials with the same operator, inverting for NOR only at stage 2.
REQ-017 Global advance enable en = !out_valid || out_ready; in_ready = en; both stages hold all registers when en = 0.
REQ-018 Stage 1 valid loads in_valid when en = 1; stage 2 valid (out_valid) loads stage 1 valid when en = 1.
REQ-019 Latency: result of a beat accepted in cycle N has out_valid = 1 in cycle N+2 when no stall occurs; each stall cycle adds one.
REQ-020 Throughput: one beat per cycle while out_ready = 1; no bubble is inserted on back-to-back beats.
REQ-021 y and op are stable while out_valid = 1 and out_ready = 0; no beat is dropped or duplicated under any out_ready pattern.
REQ-022 in_valid = 0 with en = 1 shifts a bubble; y is don't-care when out_valid = 0 but is driven (no X).
REQ-023 op changes are beat-local: each beat is reduced with the op sampled at its own accept.

Reset
REQ-024 rst = 1 asynchronously clears stage 1 valid, out_valid, y, all partial registers, and sticky to 0.
REQ-025 in_ready = 1 during and immediately after reset; in-flight beats at reset are discarded without a transfer.
REQ-026 Reset released mid-stream: first accepted beat after release follows REQ-019 exactly.

Configuration
REQ-027 Macro GATE_REDUCE_STICKY_EN defined: sticky sets to 1 on any transfer with y = 1 and holds until acc_clr = 1.
REQ-028 With the macro, acc_clr = 1 in a transfer cycle: sticky loads that cycle's y (clear then accumulate); acc_clr with no transfer: sticky becomes 0.
REQ-029 Macro undefined: sticky tied to 0, acc_clr ignored, no accumulator register synthesised; all other behaviour identical.

Verification
REQ-030 WIDTH=8, op=00, a=8'h00 then 8'h10 back-to-back, out_ready=1 -> y=0 in cycle 2, y=1 in cycle 3, out_valid high both cycles.
REQ-031 WIDTH=5, op=01, a=5'h1F then 5'h1E -> y=1 then y=0 (padding identity correct); op=10, a=5'h07 -> y=1; op=11, a=5'h00 -> y=1.
REQ-032 WIDTH=8, 4 consecutive beats, out_ready low cycles 3..5 -> in_ready low while stalled, y/out_valid frozen, all 4 results delivered in order with no loss.
REQ-033 Assert rst for 1 cycle with 2 beats in flight -> out_valid=0, y=0, sticky=0 asynchronously; no stale result appears afterwards.
REQ-034 GATE_REDUCE_STICKY_EN defined: transfers y=0,1,0 -> sticky 0,1,1; acc_clr with a y=0 transfer -> sticky=0; acc_clr with a y=1 transfer -> sticky=1.
REQ-035 GATE_REDUCE_STICKY_EN undefined: same stimulus as REQ-034 -> sticky stays 0 throughout; y sequence unchanged.
